divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; operands and op are captured on the edge where start=1 is accepted.
REQ-005 op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 dividend  input  32  numerator, two's complement for signed ops.
REQ-007 divisor  input  32  denominator, two's complement for signed ops.
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  single-cycle pulse; result is valid while done=1.
REQ-010 result  output  32  quotient or remainder selected by the captured op.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-013 On acceptance (edge E0), the block SHALL capture op, the operand magnitudes and the operand signs, clear the partial remainder, load the 6-bit iteration counter with 0, and enter RUN with busy=1.
REQ-014 Normal operation: edges E1..E32 SHALL each perform one restoring shift-subtract step, MSB first, on 32-bit unsigned magnitudes using a 33-bit subtraction.
REQ-015 At edge E33 the block SHALL apply the sign fixup, load result, set done=1 and busy=0, and enter DONE.
REQ-016 Signed fixup: the quotient SHALL be negated when the dividend and divisor signs differ; the remainder SHALL take the sign of the dividend.
REQ-017 Divide by zero (divisor=0) SHALL bypass RUN: at E1 the block SHALL set result=32'hFFFFFFFF for DIV and DIVU, or result=dividend for REM and REMU, and set done=1.
REQ-018 Signed overflow (op=DIV or REM, dividend=32'h80000000, divisor=32'hFFFFFFFF) SHALL bypass RUN: at E1 the block SHALL set result=32'h80000000 for DIV or 0 for REM, and set done=1.
REQ-019 done SHALL be high for exactly one cycle; in DONE, the next edge SHALL return the FSM to IDLE unless start=1, in which case a new operation SHALL be accepted (back-to-back).
REQ-020 result SHALL hold its last value after done falls, until the next completion or reset.
REQ-021 busy and done SHALL never both be 1 in the same cycle.
REQ-022 Operand inputs SHALL be ignored after the acceptance edge; they may change freely during RUN.

Reset
REQ-023 When reset=1 at a rising edge, the FSM SHALL enter IDLE and set busy=0, done=0, result=0, and clear the counter and all datapath registers.
REQ-024 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never produce done.

Verification
REQ-025 DIVU 100/7 -> done exactly 33 edges after the start edge, result=14; the same operands with REMU -> result=2.
REQ-026 DIV -20/3 -> result=32'hFFFFFFFA (-6); REM -20/3 -> result=32'hFFFFFFFE (-2).
REQ-027 DIV 5/0 -> done at E1, result=32'hFFFFFFFF; REMU 5/0 -> done at E1, result=5.
REQ-028 DIV 32'h80000000/32'hFFFFFFFF -> done at E1, result=32'h80000000; the same operands with REM -> result=0.
REQ-029 start pulsed at cycle 10 of a RUN -> ignored, and the original result is delivered at E33; start held high in the DONE cycle -> a second operation is accepted with no IDLE gap.
REQ-030 reset asserted at E15 of a RUN -> next cycle busy=0, done=0, result=0, and no done pulse ever appears for the aborted operation.

Source files
------------

// File: rtl/divider_unit.sv
// rtl/divider_unit.sv - 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module divider_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvs_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [5:0]  count;
  logic        bypass;
  logic [31:0] bypass_res;

  logic        signed_in, dvd_neg_in, dvs_neg_in, div_zero_in, ovf_in;
  logic [31:0] dvd_mag_in, dvs_mag_in, bypass_res_in;
  logic        accept, finish, ge;
  logic [32:0] partial, diff;
  logic [31:0] q_fix, r_fix, final_res;

  always_comb begin
    signed_in   = ~op[0];
    dvd_neg_in  = signed_in & dividend[31];
    dvs_neg_in  = signed_in & divisor[31];
    dvd_mag_in  = dvd_neg_in ? (32'd0 - dividend) : dividend;
    dvs_mag_in  = dvs_neg_in ? (32'd0 - divisor) : divisor;
    div_zero_in = (divisor == 32'd0);
    ovf_in      = signed_in & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
    // Special cases are resolved at capture time so RUN can finish after one edge.
    if (div_zero_in)
      bypass_res_in = op[1] ? dividend : 32'hFFFF_FFFF;
    else
      bypass_res_in = op[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    // Partial remainder can reach 33 bits after the shift; bit 32 set means it always fits.
    partial   = {rem, quo[31]};
    diff      = partial - {1'b0, dvs_mag};
    ge        = partial[32] | ~diff[32];
    q_fix     = (dvd_neg ^ dvs_neg) ? (32'd0 - quo) : quo;
    r_fix     = dvd_neg ? (32'd0 - rem) : rem;
    final_res = op_q[1] ? r_fix : q_fix;
  end

  assign accept = start & (state != RUN);
  assign finish = (state == RUN) & (bypass | (count == 6'd32));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= 2'd0;
      dvd_neg    <= 1'b0;
      dvs_neg    <= 1'b0;
      dvs_mag    <= 32'd0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      count      <= 6'd0;
      bypass     <= 1'b0;
      bypass_res <= 32'd0;
      result     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= op;
        dvd_neg    <= dvd_neg_in;
        dvs_neg    <= dvs_neg_in;
        dvs_mag    <= dvs_mag_in;
        quo        <= dvd_mag_in;
        rem        <= 32'd0;
        count      <= 6'd0;
        bypass     <= div_zero_in | ovf_in;
        bypass_res <= bypass_res_in;
      end else if (state == RUN) begin
        if (finish) begin
          result <= bypass ? bypass_res : final_res;
        end else begin
          rem   <= ge ? diff[31:0] : partial[31:0];
          quo   <= {quo[30:0], ge};
          count <= count + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// tb/tb_divider_unit.sv - vector table plus scoreboard bench for divider_unit
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          e0;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;

  divider_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy === 1'b1 && done === 1'b1) overlap++;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = sbq.pop_front();
        check32("result", result, e.res);
        check_int("latency", cyc - e.e0, e.lat);
      end
    end
  end

  // Called at a negedge; the following posedge is the acceptance edge.
  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sbq.push_back('{r, cyc + 1, lat});
    @(negedge clk);
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    dividend = 32'd0;
    divisor  = 32'd0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{OP_DIV,  32'hFFFFFFEC,   32'd3,          32'hFFFFFFFA,   33});
    vecs.push_back('{OP_REM,  32'hFFFFFFEC,   32'd3,          32'hFFFFFFFE,   33});
    vecs.push_back('{OP_DIV,  32'd20,         32'hFFFFFFFD,   32'hFFFFFFFA,   33});
    vecs.push_back('{OP_REM,  32'd20,         32'hFFFFFFFD,   32'd2,          33});
    vecs.push_back('{OP_DIV,  32'hFFFFFFEC,   32'hFFFFFFFD,   32'd6,          33});
    vecs.push_back('{OP_REM,  32'hFFFFFFEC,   32'hFFFFFFFD,   32'hFFFFFFFE,   33});
    vecs.push_back('{OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{OP_REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1});
    vecs.push_back('{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
    vecs.push_back('{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
    vecs.push_back('{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33});
    vecs.push_back('{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33});
    vecs.push_back('{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33});
    vecs.push_back('{OP_REMU, 32'hFFFFFFFF,   32'd10,         32'd5,          33});
    vecs.push_back('{OP_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          33});
    vecs.push_back('{OP_REMU, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          33});
    vecs.push_back('{OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33});
    vecs.push_back('{OP_REM,  32'h80000000,   32'd3,          32'hFFFFFFFE,   33});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFFFFFF,   32'hFFFFFFF9,   33});
    vecs.push_back('{OP_DIVU, 32'd7,          32'd100,        32'd0,          33});
    vecs.push_back('{OP_REMU, 32'd7,          32'd100,        32'd7,          33});

    repeat (3) @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      wait_drain("vector");
    end

    // start during RUN must not disturb the operation in flight
    drive(OP_DIVU, 32'd1000, 32'd7, 32'd142, 33);
    repeat (9) @(negedge clk);
    op = OP_DIV; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore_start");

    // back-to-back: start held in the DONE cycle
    drive(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    begin
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check32("b2b_done_seen", {31'd0, done}, 32'd1);
    end
    drive(OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    check32("b2b_busy_no_gap", {31'd0, busy}, 32'd1);
    wait_drain("back_to_back");

    // reset at E15 aborts the operation with no done pulse
    drive(OP_DIVU, 32'd12345, 32'd3, 32'd4115, 33);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_done", {31'd0, done}, 32'd0);
    check32("abort_result", result, 32'd0);
    reset = 1'b0;
    sbq.delete();
    repeat (50) @(negedge clk);

    check_int("busy_done_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
